window_3x3_gen: RTL

- Streaming 3x3 neighbourhood generator placed directly upstream of the edge-detection stage.
- Accepts one raster-order 8-bit pixel per valid cycle and buffers two previous image rows in line buffers.
- Presents the nine window pixels win1..win9 in the order the edge detector consumes them: win1 top-left, win2 top-centre, win3 top-right, win4..win6 middle row, win7..win9 bottom row.
- Flags each complete window with a one-cycle valid.

---
 rtl/window_3x3_gen.sv | 126 ++++++++++++
 1 files changed

// File: rtl/window_3x3_gen.sv
// window_3x3_gen: streaming 3x3 neighbourhood generator built on two line buffers.
// One registered window is emitted per accepted pixel at row >= 2 and col >= 2.
module window_3x3_gen #(
   parameter int IMG_WIDTH  = 512,
   parameter int IMG_HEIGHT = 512,
   parameter int DATA_W     = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   input  logic                          in_sof,
   input  logic [DATA_W-1:0]             in_pixel,
   output logic [DATA_W-1:0]             win1,
   output logic [DATA_W-1:0]             win2,
   output logic [DATA_W-1:0]             win3,
   output logic [DATA_W-1:0]             win4,
   output logic [DATA_W-1:0]             win5,
   output logic [DATA_W-1:0]             win6,
   output logic [DATA_W-1:0]             win7,
   output logic [DATA_W-1:0]             win8,
   output logic [DATA_W-1:0]             win9,
   output logic                          out_valid,
   output logic [$clog2(IMG_HEIGHT)-1:0] out_row,
   output logic [$clog2(IMG_WIDTH)-1:0]  out_col,
   output logic                          frame_done
);

   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);
   localparam logic [CW-1:0] C_LAST = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] R_LAST = RW'(IMG_HEIGHT - 1);

   logic [CW-1:0]     r_col;
   logic [RW-1:0]     r_row;
   logic [DATA_W-1:0] r_lb_a [IMG_WIDTH];
   logic [DATA_W-1:0] r_lb_b [IMG_WIDTH];
   logic [DATA_W-1:0] r_win  [9];
   logic              r_ov;
   logic              r_done;
   logic [RW-1:0]     r_orow;
   logic [CW-1:0]     r_ocol;

   logic              w_acc;
   logic [CW-1:0]     w_c;
   logic [RW-1:0]     w_r;
   logic [DATA_W-1:0] w_a;
   logic [DATA_W-1:0] w_b;
   logic              w_qual;
   logic              w_eol;
   logic              w_last;

   // in_sof forces the accepted pixel to (0,0) whatever the counters hold
   assign w_acc  = in_valid;
   assign w_c    = in_sof ? '0 : r_col;
   assign w_r    = in_sof ? '0 : r_row;
   assign w_a    = r_lb_a[w_c];
   assign w_b    = r_lb_b[w_c];
   assign w_qual = (w_r >= RW'(2)) && (w_c >= CW'(2));
   assign w_eol  = (w_c == C_LAST);
   assign w_last = w_eol && (w_r == R_LAST);

   always_ff @(posedge clk) begin
      if (w_acc) begin
         r_lb_a[w_c] <= r_lb_b[w_c];
         r_lb_b[w_c] <= in_pixel;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 9; i++) r_win[i] <= '0;
      end else if (w_acc) begin
         r_win[0] <= r_win[1];
         r_win[1] <= r_win[2];
         r_win[2] <= w_a;
         r_win[3] <= r_win[4];
         r_win[4] <= r_win[5];
         r_win[5] <= w_b;
         r_win[6] <= r_win[7];
         r_win[7] <= r_win[8];
         r_win[8] <= in_pixel;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_col  <= '0;
         r_row  <= '0;
         r_ov   <= 1'b0;
         r_done <= 1'b0;
         r_orow <= '0;
         r_ocol <= '0;
      end else begin
         r_ov   <= w_acc && w_qual;
         r_done <= w_acc && w_last;
         if (w_acc) begin
            if (w_qual) begin
               r_orow <= w_r - RW'(1);
               r_ocol <= w_c - CW'(1);
            end
            if (w_eol) begin
               r_col <= '0;
               r_row <= (w_r == R_LAST) ? '0 : w_r + RW'(1);
            end else begin
               r_col <= w_c + CW'(1);
               r_row <= w_r;
            end
         end
      end
   end

   assign win1       = r_win[0];
   assign win2       = r_win[1];
   assign win3       = r_win[2];
   assign win4       = r_win[3];
   assign win5       = r_win[4];
   assign win6       = r_win[5];
   assign win7       = r_win[6];
   assign win8       = r_win[7];
   assign win9       = r_win[8];
   assign out_valid  = r_ov;
   assign out_row    = r_orow;
   assign out_col    = r_ocol;
   assign frame_done = r_done;

endmodule
